// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive FIFO slice.
// Optional level port: UART_RX_FIFO_LEVEL_EN.
package uart_pkg;

  localparam int UART_DBIT        = 8;
  localparam int UART_FIFO_ADDR_W = 4;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    NOP      = 2'b00,
    POP      = 2'b01,
    PUSH     = 2'b10,
    PUSH_POP = 2'b11
  } fifo_op_t;

  function automatic fifo_op_t fifo_decode(
    input logic wr,
    input logic rd
  );
    return fifo_op_t'({wr, rd});
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer, flag and overflow control for the UART receive FIFO.
// Optional level counter: UART_RX_FIFO_LEVEL_EN.
module fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic              clr_ovf,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic              empty,
  output logic              full,
`ifdef UART_RX_FIFO_LEVEL_EN
  output logic [ADDR_W:0]   level,
`endif
  output logic              ovf
);

  localparam logic [ADDR_W-1:0] P_ONE = 1;

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W-1:0] w_wptr_nx;
  logic [ADDR_W-1:0] w_rptr_nx;
  logic [ADDR_W-1:0] w_winc;
  logic [ADDR_W-1:0] w_rinc;
  logic              r_empty;
  logic              r_full;
  logic              r_ovf;
  logic              w_empty_nx;
  logic              w_full_nx;
  logic              w_ovf_nx;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  fifo_op_t          w_op;

  assign w_op   = fifo_decode(wr, rd);
  assign w_winc = r_wptr + P_ONE;
  assign w_rinc = r_rptr + P_ONE;

  // A simultaneous pop frees the slot, so push-pop
  // always accepts the push, even when full.
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_drop = 1'b0;
    unique case (w_op)
      NOP: ;
      POP: w_pop = !r_empty;
      PUSH: begin
        w_push = !r_full;
        w_drop = r_full;
      end
      PUSH_POP: begin
        w_push = 1'b1;
        w_pop  = !r_empty;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wptr_nx  = r_wptr;
    w_rptr_nx  = r_rptr;
    w_empty_nx = r_empty;
    w_full_nx  = r_full;
    if (w_push) w_wptr_nx = w_winc;
    if (w_pop)  w_rptr_nx = w_rinc;
    if (w_push && !w_pop) begin
      w_empty_nx = 1'b0;
      w_full_nx  = (w_winc == r_rptr);
    end else if (w_pop && !w_push) begin
      w_full_nx  = 1'b0;
      w_empty_nx = (w_rinc == r_wptr);
    end
    w_ovf_nx = w_drop | (r_ovf & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nx;
      r_rptr  <= w_rptr_nx;
      r_empty <= w_empty_nx;
      r_full  <= w_full_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

`ifdef UART_RX_FIFO_LEVEL_EN
  localparam logic [ADDR_W:0] P_LONE = 1;

  logic [ADDR_W:0] r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + P_LONE;
    end else if (w_pop && !w_push) begin
      r_level <= r_level - P_LONE;
    end
  end

  assign level = r_level;
`endif

  assign w_en   = w_push;
  assign w_addr = r_wptr;
  assign r_addr = r_rptr;
  assign empty  = r_empty;
  assign full   = r_full;
  assign ovf    = r_ovf;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: FWFT circular buffer with sticky overflow.
// Optional level port: UART_RX_FIFO_LEVEL_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full,
  output logic            ovf,
`ifdef UART_RX_FIFO_LEVEL_EN
  output logic [ADDR_W:0] level,
`endif
  input  logic            clr_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DBIT-1:0]   r_mem [DEPTH];
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;

  fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .rd      (rd),
    .clr_ovf (clr_ovf),
    .w_en    (w_we),
    .w_addr  (w_waddr),
    .r_addr  (w_raddr),
    .empty   (empty),
    .full    (full),
`ifdef UART_RX_FIFO_LEVEL_EN
    .level   (level),
`endif
    .ovf     (ovf)
  );

  // Storage is deliberately unreset; the flags gate validity.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_data;
  end

  assign r_data = r_mem[w_raddr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue model.
// Level checks enabled with UART_RX_FIFO_LEVEL_EN.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int AW    = UART_FIFO_ADDR_W;
  localparam int DEPTH = 1 << AW;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr      = 1'b0;
  logic       rd      = 1'b0;
  logic       clr_ovf = 1'b0;
  uart_byte_t w_data  = '0;
  uart_byte_t r_data;
  logic       empty;
  logic       full;
  logic       ovf;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [AW:0] level;
`endif

  uart_rx_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .w_data  (w_data),
    .rd      (rd),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
`ifdef UART_RX_FIFO_LEVEL_EN
    .level   (level),
`endif
    .clr_ovf (clr_ovf)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         errors  = 0;
  uart_byte_t q[$];
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".empty"}, {31'b0, empty}, {31'b0, q.size() == 0});
    chk({tag, ".full"}, {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, m_ovf});
    if (q.size() != 0)
      chk({tag, ".rdata"}, {24'b0, r_data}, {24'b0, q[0]});
`ifdef UART_RX_FIFO_LEVEL_EN
    chk({tag, ".level"}, {27'b0, level}, q.size());
`endif
  endtask

  task automatic step(input bit w, input bit r,
                      input uart_byte_t d, input bit c,
                      input string tag);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    wr = w; rd = r; w_data = d; clr_ovf = c;
    @(posedge clk);
    pop_ok  = r && q.size() > 0;
    push_ok = w && (q.size() < DEPTH || pop_ok);
    if (pop_ok) void'(q.pop_front());
    if (push_ok) q.push_back(d);
    if (w && !push_ok) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    #1;
    check_state(tag);
    wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic push(input uart_byte_t d, input string tag);
    step(1'b1, 1'b0, d, 1'b0, tag);
  endtask

  task automatic pop(input string tag);
    step(1'b0, 1'b1, 8'h00, 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) pop("idle_rd");
    chk("idle_empty", {31'b0, empty}, 32'd1);

    push(8'h41, "p41");
    push(8'h42, "p42");
    push(8'h43, "p43");
    chk("head41", {24'b0, r_data}, 32'h41);
    pop("q1");
    chk("head42", {24'b0, r_data}, 32'h42);
    pop("q2");
    chk("head43", {24'b0, r_data}, 32'h43);
    pop("q3");
    chk("empty3", {31'b0, empty}, 32'd1);

    for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(i), "fill");
    chk("full16", {31'b0, full}, 32'd1);
    push(8'hFF, "drop");
    chk("ovf17", {31'b0, ovf}, 32'd1);
    chk("head00", {24'b0, r_data}, 32'h00);
    for (int i = 0; i < DEPTH; i++) pop("drain");
    step(1'b0, 1'b0, 8'h00, 1'b1, "clr");

    for (int i = 0; i < DEPTH; i++) push(uart_byte_t'(i), "fill2");
    step(1'b1, 1'b1, 8'hAA, 1'b0, "full_pp");
    chk("pp_head01", {24'b0, r_data}, 32'h01);
    chk("pp_full", {31'b0, full}, 32'd1);
    chk("pp_noovf", {31'b0, ovf}, 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) pop("drain2");
    chk("last_aa", {24'b0, r_data}, 32'hAA);
    pop("drain2_last");
    step(1'b1, 1'b1, 8'h55, 1'b0, "empty_pp");
    chk("ep_head55", {24'b0, r_data}, 32'h55);
    pop("ep_pop");

    for (int i = 0; i < 40; i++) begin
      push(uart_byte_t'(8'h80 + i), "wrap_push");
      pop("wrap_pop");
    end

    for (int i = 0; i < DEPTH; i++)
      push(uart_byte_t'($urandom), "fill3");
    step(1'b1, 1'b0, 8'h99, 1'b1, "ovf_clr_same");
    chk("set_wins", {31'b0, ovf}, 32'd1);
    for (int i = 0; i < DEPTH - 5; i++) pop("to5");
    async_reset("mid_rst");
    push(8'h7E, "post_rst");
    chk("head7e", {24'b0, r_data}, 32'h7E);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 4,
           uart_byte_t'($urandom),
           $urandom_range(0, 7) == 0,
           "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
